// File: rtl/mac_array.sv
// Weight-stationary row x col systolic MAC grid: 4-bit signed weights, 2-bit or 4-bit unsigned activations.
// Define MAC_ARRAY_SAT_EN to make each PE accumulation saturate instead of wrap.
module mac_array #(
  parameter int bw      = 2,
  parameter int b_bw    = 4,
  parameter int psum_bw = 32,
  parameter int col     = 2,
  parameter int row     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [row*2*bw-1:0]      in_w,
  input  logic [2:0]               inst_w,
  input  logic [psum_bw*col-1:0]   in_n,
  output logic [psum_bw*col-1:0]   out_s,
  output logic [col-1:0]           valid
);

  localparam int DW = 2 * bw;

  logic [2:0]         inst_skew_q [row];
  logic [2:0]         inst_skew_d [row];

  logic [2:0]         pe_inst_q   [row][col];
  logic [2:0]         pe_inst_d   [row][col];
  logic [DW-1:0]      pe_data_q   [row][col];
  logic [DW-1:0]      pe_data_d   [row][col];
  logic [b_bw-1:0]    w0_q        [row][col];
  logic [b_bw-1:0]    w0_d        [row][col];
  logic [b_bw-1:0]    w1_q        [row][col];
  logic [b_bw-1:0]    w1_d        [row][col];
  logic [1:0]         fill_q      [row][col];
  logic [1:0]         fill_d      [row][col];
  logic [psum_bw-1:0] psum_q      [row][col];
  logic [psum_bw-1:0] psum_d      [row][col];
  logic               exec_q      [row][col];
  logic               exec_d      [row][col];

  logic [2:0]         west_inst_s  [row][col];
  logic [DW-1:0]      west_data_s  [row][col];
  logic [psum_bw-1:0] north_psum_s [row][col];

  function automatic logic pe_full(input logic mode, input logic [1:0] fill);
    logic full;
    if (mode) begin
      full = (fill >= 2'd1);
    end else begin
      full = (fill >= 2'd2);
    end
    return full;
  endfunction

  // Unsigned activation lanes times sign-extended weights; in 4-bit mode the second lane is unused.
  function automatic logic [psum_bw-1:0] mac_fn(input logic mode, input logic [DW-1:0] act,
                                                input logic [b_bw-1:0] w0, input logic [b_bw-1:0] w1);
    logic signed [psum_bw-1:0] a0, a1, sw0, sw1;
    sw0 = {{(psum_bw-b_bw){w0[b_bw-1]}}, w0};
    sw1 = {{(psum_bw-b_bw){w1[b_bw-1]}}, w1};
    if (mode) begin
      a0 = {{(psum_bw-DW){1'b0}}, act};
      a1 = {psum_bw{1'b0}};
    end else begin
      a0 = {{(psum_bw-bw){1'b0}}, act[bw-1:0]};
      a1 = {{(psum_bw-bw){1'b0}}, act[DW-1:bw]};
    end
    return a0 * sw0 + a1 * sw1;
  endfunction

  function automatic logic [psum_bw-1:0] acc_fn(input logic [psum_bw-1:0] a, input logic [psum_bw-1:0] b);
    logic [psum_bw-1:0] res;
`ifdef MAC_ARRAY_SAT_EN
    logic [psum_bw:0] sum;
    sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (sum[psum_bw] != sum[psum_bw-1]) begin
      res = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      res = sum[psum_bw-1:0];
    end
`else
    res = a + b;
`endif
    return res;
  endfunction

  // Instruction skew: row r sees inst_w delayed by r+1 cycles.
  always_comb begin
    inst_skew_d[0] = inst_w;
    for (int r = 1; r < row; r++) begin
      inst_skew_d[r] = inst_skew_q[r-1];
    end
  end

  // Neighbour wiring: west-edge inputs and east-moving pairs, north seeds and south-moving psums.
  always_comb begin
    for (int r = 0; r < row; r++) begin
      west_inst_s[r][0] = inst_skew_q[r];
      west_data_s[r][0] = in_w[r*DW +: DW];
      for (int c = 1; c < col; c++) begin
        west_inst_s[r][c] = pe_inst_q[r][c-1];
        west_data_s[r][c] = pe_data_q[r][c-1];
      end
    end
    for (int c = 0; c < col; c++) begin
      north_psum_s[0][c] = in_n[c*psum_bw +: psum_bw];
      for (int r = 1; r < row; r++) begin
        north_psum_s[r][c] = psum_q[r-1][c];
      end
    end
  end

  // Per-PE next state: weight capture on load, accumulate on exec, forward the rest east.
  always_comb begin
    for (int r = 0; r < row; r++) begin
      for (int c = 0; c < col; c++) begin
        pe_inst_d[r][c] = west_inst_s[r][c];
        pe_data_d[r][c] = west_data_s[r][c];
        w0_d[r][c]      = w0_q[r][c];
        w1_d[r][c]      = w1_q[r][c];
        fill_d[r][c]    = fill_q[r][c];
        psum_d[r][c]    = psum_q[r][c];
        exec_d[r][c]    = 1'b0;
        if (west_inst_s[r][c][0]) begin
          if (!pe_full(west_inst_s[r][c][2], fill_q[r][c])) begin
            case (fill_q[r][c])
              2'd0:    w0_d[r][c] = west_data_s[r][c];
              default: w1_d[r][c] = west_data_s[r][c];
            endcase
            fill_d[r][c]    = fill_q[r][c] + 2'd1;
            // A consumed weight must not reach the next column as a load.
            pe_inst_d[r][c] = {west_inst_s[r][c][2], 2'b00};
            pe_data_d[r][c] = {DW{1'b0}};
          end else begin
            pe_inst_d[r][c] = west_inst_s[r][c];
          end
        end else if (west_inst_s[r][c][1]) begin
          psum_d[r][c] = acc_fn(north_psum_s[r][c],
                                mac_fn(west_inst_s[r][c][2], west_data_s[r][c], w0_q[r][c], w1_q[r][c]));
          exec_d[r][c] = 1'b1;
        end else begin
          exec_d[r][c] = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < row; r++) begin
        inst_skew_q[r] <= 3'b000;
        for (int c = 0; c < col; c++) begin
          pe_inst_q[r][c] <= 3'b000;
          pe_data_q[r][c] <= {DW{1'b0}};
          w0_q[r][c]      <= {b_bw{1'b0}};
          w1_q[r][c]      <= {b_bw{1'b0}};
          fill_q[r][c]    <= 2'd0;
          psum_q[r][c]    <= {psum_bw{1'b0}};
          exec_q[r][c]    <= 1'b0;
        end
      end
    end else begin
      for (int r = 0; r < row; r++) begin
        inst_skew_q[r] <= inst_skew_d[r];
        for (int c = 0; c < col; c++) begin
          pe_inst_q[r][c] <= pe_inst_d[r][c];
          pe_data_q[r][c] <= pe_data_d[r][c];
          w0_q[r][c]      <= w0_d[r][c];
          w1_q[r][c]      <= w1_d[r][c];
          fill_q[r][c]    <= fill_d[r][c];
          psum_q[r][c]    <= psum_d[r][c];
          exec_q[r][c]    <= exec_d[r][c];
        end
      end
    end
  end

  // South edge: bottom-row registers drive the outputs directly.
  always_comb begin
    out_s = {(psum_bw*col){1'b0}};
    valid = {col{1'b0}};
    for (int c = 0; c < col; c++) begin
      out_s[c*psum_bw +: psum_bw] = psum_q[row-1][c];
      valid[c]                    = exec_q[row-1][c];
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// Bench for mac_array: cycle-indexed behavioural model plus literal result checks.
`timescale 1ns/1ps
module tb_mac_array;
  localparam int BW = 2, B_BW = 4, PSUM_BW = 32, COL = 2, ROW = 2, MAXC = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [ROW*2*BW-1:0]    in_w;
  logic [2:0]             inst_w;
  logic [PSUM_BW*COL-1:0] in_n;
  logic [PSUM_BW*COL-1:0] out_s;
  logic [COL-1:0]         valid;

  mac_array #(.bw(BW), .b_bw(B_BW), .psum_bw(PSUM_BW), .col(COL), .row(ROW)) dut (
    .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w),
    .in_n(in_n), .out_s(out_s), .valid(valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc, cyc_n;
  bit run;

  logic [2:0]  inst_h [MAXC];
  logic [3:0]  win_h  [MAXC][ROW];
  logic [31:0] n_h    [MAXC][COL];
  longint      contrib[MAXC][ROW][COL];
  longint      wt     [ROW][2*COL];
  int          lcnt   [ROW];
  logic [31:0] last_out[COL];
  int          lit_cyc[COL];
  logic [31:0] lit_val[COL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sx4(input logic [3:0] v);
    logic signed [3:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint acc(input longint a, input longint b);
    longint s;
`ifndef MAC_ARRAY_SAT_EN
    logic signed [31:0] t;
`endif
    s = a + b;
`ifdef MAC_ARRAY_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
`else
    t = s[31:0];
    return longint'(t);
`endif
  endfunction

  // Row r acts in cycle k on the instruction issued at k-1-r and its own in_w slice of cycle k.
  task automatic model_step(input int k);
    logic [2:0] ins;
    logic [3:0] d;
    int cap;
    for (int r = 0; r < ROW; r++) begin
      if (k - 1 - r >= 0) begin
        ins = inst_h[k-1-r];
        d   = win_h[k][r];
        if (ins[0]) begin
          cap = ins[2] ? 1 : 2;
          if (lcnt[r] < COL * cap) begin
            wt[r][lcnt[r]] = sx4(d);
            lcnt[r]++;
          end
        end else if (ins[1]) begin
          for (int c = 0; c < COL; c++) begin
            if (ins[2]) contrib[k-1-r][r][c] = longint'(d) * wt[r][c];
            else contrib[k-1-r][r][c] = longint'(d[1:0]) * wt[r][2*c] + longint'(d[3:2]) * wt[r][2*c+1];
          end
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) begin
      inst_h[i] = 3'b000;
      for (int r = 0; r < ROW; r++) begin
        win_h[i][r] = 4'h0;
        for (int c = 0; c < COL; c++) contrib[i][r][c] = 0;
      end
      for (int c = 0; c < COL; c++) n_h[i][c] = 32'd0;
    end
    for (int r = 0; r < ROW; r++) begin
      lcnt[r] = 0;
      for (int j = 0; j < 2*COL; j++) wt[r][j] = 0;
    end
    for (int c = 0; c < COL; c++) begin
      last_out[c] = 32'd0;
      lit_cyc[c]  = -1;
      lit_val[c]  = 32'd0;
    end
  endtask

  task automatic step(input logic [2:0] ins, input logic [3:0] w1, input logic [3:0] w0,
                      input logic [31:0] n0, input logic [31:0] n1);
    if (cyc_n >= MAXC) begin
      $display("FAIL history_overflow: got %0d expected below %0d", cyc_n, MAXC);
      $fatal(1);
    end
    inst_w = ins;
    in_w   = {w1, w0};
    in_n   = {n1, n0};
    inst_h[cyc_n]   = ins;
    win_h[cyc_n][0] = w0;
    win_h[cyc_n][1] = w1;
    n_h[cyc_n][0]   = n0;
    n_h[cyc_n][1]   = n1;
    model_step(cyc_n);
    cyc = cyc_n;
    cyc_n++;
    run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] n0, input logic [31:0] n1);
    repeat (n) step(3'b000, 4'h0, 4'h0, n0, n1);
  endtask

  // Asserted mid-cycle so it is truly asynchronous; outputs must read zero while held.
  task automatic do_reset();
    #2;
    reset  = 1'b0;
    run    = 1'b0;
    inst_w = 3'b000;
    in_w   = '0;
    in_n   = '0;
    #1;
    chk("rst_async_out0", out_s[31:0], 32'd0);
    chk("rst_async_out1", out_s[63:32], 32'd0);
    chk("rst_async_valid", {30'd0, valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_out0", out_s[31:0], 32'd0);
    chk("rst_held_out1", out_s[63:32], 32'd0);
    chk("rst_held_valid", {30'd0, valid}, 32'd0);
    model_clear();
    cyc   = 0;
    cyc_n = 0;
    reset = 1'b1;
  endtask

  task automatic seq_mode1(input logic [31:0] n0, input logic [31:0] n1);
    step(3'b101, 4'h0, 4'h0, n0, n1);
    step(3'b101, 4'h0, 4'h7, n0, n1);
    step(3'b101, 4'h5, 4'hB, n0, n1);
    step(3'b110, 4'h9, 4'h0, n0, n1);
    step(3'b100, 4'h0, 4'hF, n0, n1);
    step(3'b100, 4'hF, 4'h0, n0, n1);
    idle(6, n0, n1);
  endtask

  task automatic load_mode0(input logic [31:0] n0, input logic [31:0] n1);
    step(3'b001, 4'h0, 4'h0, n0, n1);
    step(3'b001, 4'h0, 4'h7, n0, n1);
    step(3'b001, 4'h5, 4'h6, n0, n1);
    step(3'b001, 4'h4, 4'hB, n0, n1);
    step(3'b001, 4'h9, 4'hA, n0, n1);
    step(3'b001, 4'h8, 4'h0, n0, n1);
    step(3'b001, 4'h8, 4'h0, n0, n1);
  endtask

  // Single compare process: model expectation every cycle, plus literal pins where armed.
  always @(negedge clk) begin
    int t;
    logic ev;
    longint s;
    if (run) begin
      for (int c = 0; c < COL; c++) begin
        t  = cyc - 1 - ROW - c;
        ev = 1'b0;
        if (t >= 0) ev = inst_h[t][1] & ~inst_h[t][0];
        if (ev) begin
          s = longint'($signed(n_h[t+1+c][c]));
          for (int r = 0; r < ROW; r++) s = acc(s, contrib[t][r][c]);
          last_out[c] = s[31:0];
        end
        chk($sformatf("model_valid%0d", c), {31'd0, valid[c]}, {31'd0, ev});
        chk($sformatf("model_out%0d", c), out_s[c*32 +: 32], last_out[c]);
        if (cyc == lit_cyc[c]) begin
          chk($sformatf("lit_valid%0d", c), {31'd0, valid[c]}, 32'd1);
          chk($sformatf("lit_out%0d", c), out_s[c*32 +: 32], lit_val[c]);
        end
      end
    end
  end

  initial begin
    reset  = 1'b0;
    inst_w = 3'b000;
    in_w   = '0;
    in_n   = '0;
    run    = 1'b0;
    cyc    = 0;
    cyc_n  = 0;
    model_clear();
    @(posedge clk);
    #1;

    // 2-bit mode: exec at cycle 7 -> col0 at 10, col1 at 11
    do_reset();
    lit_cyc[0] = 10; lit_val[0] = 32'd66;
    lit_cyc[1] = 11; lit_val[1] = -32'sd78;
    load_mode0(32'd0, 32'd0);
    step(3'b010, 4'h0, 4'h0, 32'd0, 32'd0);
    step(3'b000, 4'h0, 4'hF, 32'd0, 32'd0);
    step(3'b000, 4'hF, 4'h0, 32'd0, 32'd0);
    idle(6, 32'd0, 32'd0);

    // 4-bit mode: exec at cycle 3 -> col0 at 6, col1 at 7
    do_reset();
    lit_cyc[0] = 6; lit_val[0] = 32'd180;
    lit_cyc[1] = 7; lit_val[1] = -32'sd180;
    seq_mode1(32'd0, 32'd0);

    // North seeds held
    do_reset();
    lit_cyc[0] = 6; lit_val[0] = 32'd280;
    lit_cyc[1] = 7; lit_val[1] = -32'sd280;
    seq_mode1(32'd100, -32'sd100);

    // Overflow at the top of the psum range
    do_reset();
    lit_cyc[0] = 6;
`ifdef MAC_ARRAY_SAT_EN
    lit_val[0] = 32'h7FFFFFFF;
`else
    lit_val[0] = 32'h800000A4;
`endif
    lit_cyc[1] = 7; lit_val[1] = -32'sd180;
    seq_mode1(32'h7FFFFFF0, 32'd0);

    // Reset in the middle of a load, then exec against cleared weights
    do_reset();
    step(3'b101, 4'h0, 4'h0, 32'd0, 32'd0);
    step(3'b101, 4'h0, 4'h7, 32'd0, 32'd0);
    step(3'b101, 4'h5, 4'hB, 32'd0, 32'd0);
    do_reset();
    lit_cyc[0] = 3; lit_val[0] = 32'd0;
    lit_cyc[1] = 4; lit_val[1] = 32'd0;
    step(3'b110, 4'h0, 4'h0, 32'd0, 32'd0);
    step(3'b100, 4'h0, 4'hF, 32'd0, 32'd0);
    step(3'b100, 4'hF, 4'h0, 32'd0, 32'd0);
    idle(5, 32'd0, 32'd0);

    // Back-to-back execs with varied activations, then a load+exec instruction that must act as load
    do_reset();
    load_mode0(32'd5, -32'sd3);
    step(3'b010, 4'h0, 4'h0, 32'd5, -32'sd3);
    step(3'b010, 4'h0, 4'h6, 32'd5, -32'sd3);
    step(3'b010, 4'h9, 4'hE, 32'd5, -32'sd3);
    step(3'b011, 4'hC, 4'h3, 32'd5, -32'sd3);
    step(3'b000, 4'h2, 4'h0, 32'd5, -32'sd3);
    idle(7, 32'd5, -32'sd3);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
